// File: rtl/pipeline_stall_monitor_pkg.sv
// Shared opcode constants, violation codes and FSM states for the pipeline stall monitor.
package pipeline_stall_monitor_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    VC_NONE             = 3'd0,
    VC_MISSING_STALL    = 3'd1,
    VC_EXCESS_STALL     = 3'd2,
    VC_UNEXPECTED_STALL = 3'd3,
    VC_SHORT_STALL      = 3'd4,
    VC_LONG_STALL       = 3'd5,
    VC_JUMP_STALL       = 3'd6
  } viol_code_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_jump(input logic [6:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/pipeline_stall_monitor_stall_expect_calc.sv
// Combinational stall-length expectation for the instruction pair currently in ID and EX.
module stall_expect_calc
  import pipeline_stall_monitor_pkg::*;
#(
  parameter int LOAD_USE_STALL    = 1,
  parameter int BRANCH_LOAD_STALL = 2,
  parameter int BRANCH_ALU_STALL  = 1
) (
  input  logic [6:0] opcode_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic [6:0] opcode_ex,
  input  logic [4:0] rd_ex,
  output logic [2:0] exp_now
);

  logic dep;
  logic ex_is_load;
  logic ex_is_alu;
  logic id_is_branch;

  always_comb begin
    dep          = (rd_ex != 5'd0) && ((rd_ex == rs1_id) || (rd_ex == rs2_id));
    ex_is_load   = (opcode_ex == OPC_LOAD);
    ex_is_alu    = (opcode_ex == OPC_OP) || (opcode_ex == OPC_OP_IMM) ||
                   (opcode_ex == OPC_LUI) || (opcode_ex == OPC_AUIPC);
    id_is_branch = (opcode_id == OPC_BRANCH);

    exp_now = 3'd0;
    if (dep) begin
      if (id_is_branch && ex_is_load)
        exp_now = 3'(BRANCH_LOAD_STALL);
      else if (id_is_branch && ex_is_alu)
        exp_now = 3'(BRANCH_ALU_STALL);
      else if (!id_is_branch && !is_jump(opcode_id) && ex_is_load)
        exp_now = 3'(LOAD_USE_STALL);
    end
  end

endmodule

// File: rtl/pipeline_stall_monitor.sv
// Watches the pipeline stall request and flags stall runs whose length disagrees with the hazard seen in ID/EX.
//
// state   | meaning
// ST_IDLE | no stall run in progress; a missing required stall is flagged here
// ST_RUN  | counting a stall run; length is judged when stall drops
module pipeline_stall_monitor
  import pipeline_stall_monitor_pkg::*;
#(
  parameter int MAX_STALL         = 2,
  parameter int LOAD_USE_STALL    = 1,
  parameter int BRANCH_LOAD_STALL = 2,
  parameter int BRANCH_ALU_STALL  = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [6:0]       opcode_ex,
  input  logic [4:0]       rd_ex,
  input  logic             stall,
  input  logic             flush,
  output logic             violation,
  output logic [2:0]       viol_code,
  output logic [2:0]       first_code,
  output logic [CNT_W-1:0] stall_total,
  output logic [CNT_W-1:0] viol_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0] exp_now;

  stall_expect_calc #(
    .LOAD_USE_STALL   (LOAD_USE_STALL),
    .BRANCH_LOAD_STALL(BRANCH_LOAD_STALL),
    .BRANCH_ALU_STALL (BRANCH_ALU_STALL)
  ) u_expect (
    .opcode_id(opcode_id),
    .rs1_id   (rs1_id),
    .rs2_id   (rs2_id),
    .opcode_ex(opcode_ex),
    .rd_ex    (rd_ex),
    .exp_now  (exp_now)
  );

  state_e           state_q, state_d;
  logic [2:0]       run_cnt_q, run_cnt_d;
  logic [2:0]       exp_lat_q, exp_lat_d;
  logic             jump_q, jump_d;
  logic             excess_q, excess_d;
  logic             violation_q, violation_d;
  viol_code_e       viol_code_q, viol_code_d;
  viol_code_e       first_code_q, first_code_d;
  logic [CNT_W-1:0] stall_total_q, stall_total_d;
  logic [CNT_W-1:0] viol_count_q, viol_count_d;

  viol_code_e flag_code;
  logic [3:0] run_nxt;

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    exp_lat_d = exp_lat_q;
    jump_d    = jump_q;
    excess_d  = excess_q;
    flag_code = VC_NONE;
    run_nxt   = {1'b0, run_cnt_q} + 4'd1;

    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          if (stall) begin
            state_d   = ST_RUN;
            run_cnt_d = 3'd1;
            exp_lat_d = exp_now;
            jump_d    = is_jump(opcode_id);
            excess_d  = 1'b0;
            if (is_jump(opcode_id))
              flag_code = VC_JUMP_STALL;
          end else if (exp_now != 3'd0) begin
            flag_code = VC_MISSING_STALL;
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d   = ST_IDLE;
          run_cnt_d = 3'd0;
          exp_lat_d = 3'd0;
        end else if (stall) begin
          if (run_cnt_q != 3'd7)
            run_cnt_d = run_cnt_q + 3'd1;
          if ((run_nxt > 4'(MAX_STALL)) && !excess_q) begin
            flag_code = VC_EXCESS_STALL;
            excess_d  = 1'b1;
          end
        end else begin
          state_d   = ST_IDLE;
          run_cnt_d = 3'd0;
          exp_lat_d = 3'd0;
          // A jump run was already reported at its first cycle.
          if (exp_lat_q == 3'd0) begin
            if (!jump_q)
              flag_code = VC_UNEXPECTED_STALL;
          end else if (run_cnt_q < exp_lat_q) begin
            flag_code = VC_SHORT_STALL;
          end else if ((run_cnt_q > exp_lat_q) && !jump_q && !excess_q) begin
            flag_code = VC_LONG_STALL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    violation_d   = (flag_code != VC_NONE);
    viol_code_d   = violation_d ? flag_code : viol_code_q;
    first_code_d  = (violation_d && (first_code_q == VC_NONE)) ? flag_code : first_code_q;
    viol_count_d  = (violation_d && (viol_count_q != CNT_MAX)) ? viol_count_q + CNT_ONE
                                                               : viol_count_q;
    stall_total_d = (stall && (stall_total_q != CNT_MAX)) ? stall_total_q + CNT_ONE
                                                          : stall_total_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      run_cnt_q     <= 3'd0;
      exp_lat_q     <= 3'd0;
      jump_q        <= 1'b0;
      excess_q      <= 1'b0;
      violation_q   <= 1'b0;
      viol_code_q   <= VC_NONE;
      first_code_q  <= VC_NONE;
      stall_total_q <= '0;
      viol_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      exp_lat_q     <= exp_lat_d;
      jump_q        <= jump_d;
      excess_q      <= excess_d;
      violation_q   <= violation_d;
      viol_code_q   <= viol_code_d;
      first_code_q  <= first_code_d;
      stall_total_q <= stall_total_d;
      viol_count_q  <= viol_count_d;
    end
  end

  assign violation   = violation_q;
  assign viol_code   = viol_code_q;
  assign first_code  = first_code_q;
  assign stall_total = stall_total_q;
  assign viol_count  = viol_count_q;

endmodule

// File: tb/tb_pipeline_stall_monitor.sv
// Directed bench for pipeline_stall_monitor; a narrow-counter instance exercises saturation.
module tb_pipeline_stall_monitor;

  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BUB  = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode_id, opcode_ex;
  logic [4:0]  rs1_id, rs2_id, rd_ex;
  logic        stall, flush;

  logic        violation;
  logic [2:0]  viol_code, first_code;
  logic [15:0] stall_total, viol_count;

  logic        violation_s;
  logic [2:0]  viol_code_s, first_code_s;
  logic [1:0]  stall_total_s, viol_count_s;

  int checks;
  int errors;

  always #5 clk = ~clk;

  pipeline_stall_monitor dut (
    .clk(clk), .reset(reset), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .opcode_ex(opcode_ex), .rd_ex(rd_ex), .stall(stall), .flush(flush),
    .violation(violation), .viol_code(viol_code), .first_code(first_code),
    .stall_total(stall_total), .viol_count(viol_count)
  );

  pipeline_stall_monitor #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .opcode_ex(opcode_ex), .rd_ex(rd_ex), .stall(stall), .flush(flush),
    .violation(violation_s), .viol_code(viol_code_s), .first_code(first_code_s),
    .stall_total(stall_total_s), .viol_count(viol_count_s)
  );

  task automatic set_in(input logic [6:0] oid, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [6:0] oex, input logic [4:0] rd,
                        input logic st, input logic fl);
    opcode_id = oid; rs1_id = r1; rs2_id = r2;
    opcode_ex = oex; rd_ex = rd; stall = st; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset state
    do_reset();
    check("rst_violation",   32'(violation),   32'd0);
    check("rst_viol_code",   32'(viol_code),   32'd0);
    check("rst_first_code",  32'(first_code),  32'd0);
    check("rst_stall_total", 32'(stall_total), 32'd0);
    check("rst_viol_count",  32'(viol_count),  32'd0);

    // Branch on load result, correct 2-cycle stall
    set_in(BEQ, 5'd5, 5'd0, LD, 5'd5, 1'b1, 1'b0);
    tick();
    check("bl_ok_c1_viol", 32'(violation), 32'd0);
    tick();
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b0, 1'b0);
    tick();
    check("bl_ok_end_viol", 32'(violation), 32'd0);
    tick();
    check("bl_ok_idle_viol", 32'(violation), 32'd0);
    check("bl_ok_stall_total", 32'(stall_total), 32'd2);
    check("bl_ok_viol_count", 32'(viol_count), 32'd0);

    // Same hazard, stall only 1 cycle -> SHORT_STALL
    do_reset();
    set_in(BEQ, 5'd5, 5'd0, LD, 5'd5, 1'b1, 1'b0);
    tick();
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b0, 1'b0);
    tick();
    check("short_viol",       32'(violation),  32'd1);
    check("short_code",       32'(viol_code),  32'd4);
    check("short_first_code", 32'(first_code), 32'd4);
    check("short_count",      32'(viol_count), 32'd1);
    tick();
    check("short_pulse_end",  32'(violation),  32'd0);

    // Load-use with no stall -> MISSING_STALL
    do_reset();
    set_in(ADD, 5'd0, 5'd7, LD, 5'd7, 1'b0, 1'b0);
    tick();
    check("missing_viol",  32'(violation),  32'd1);
    check("missing_code",  32'(viol_code),  32'd1);
    check("missing_count", 32'(viol_count), 32'd1);
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b0, 1'b0);
    tick();
    check("missing_pulse_end", 32'(violation), 32'd0);

    // Jump stalled 1 cycle -> single JUMP_STALL pulse, no UNEXPECTED at run end
    do_reset();
    set_in(JAL, 5'd0, 5'd0, BUB, 5'd0, 1'b1, 1'b0);
    tick();
    check("jump_viol", 32'(violation), 32'd1);
    check("jump_code", 32'(viol_code), 32'd6);
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b0, 1'b0);
    tick();
    check("jump_end_viol", 32'(violation), 32'd0);
    tick();
    check("jump_idle_viol", 32'(violation),  32'd0);
    check("jump_count",     32'(viol_count), 32'd1);
    check("jump_first",     32'(first_code), 32'd6);

    // 3-cycle stall with MAX_STALL=2 -> EXCESS in third cycle, no LONG afterwards
    do_reset();
    set_in(BEQ, 5'd5, 5'd0, LD, 5'd5, 1'b1, 1'b0);
    tick();
    check("excess_c1_viol", 32'(violation), 32'd0);
    tick();
    check("excess_c2_viol", 32'(violation), 32'd0);
    tick();
    check("excess_c3_viol", 32'(violation), 32'd1);
    check("excess_c3_code", 32'(viol_code), 32'd2);
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b0, 1'b0);
    tick();
    check("excess_end_viol", 32'(violation), 32'd0);
    tick();
    check("excess_idle_viol", 32'(violation),   32'd0);
    check("excess_code_held", 32'(viol_code),   32'd2);
    check("excess_count",     32'(viol_count),  32'd1);
    check("excess_stall_tot", 32'(stall_total), 32'd3);

    // UNEXPECTED, LONG, UNEXPECTED, MISSING; narrow counters saturate at 3
    do_reset();
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b1, 1'b0);
    tick();
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b0, 1'b0);
    tick();
    check("unexp_viol", 32'(violation), 32'd1);
    check("unexp_code", 32'(viol_code), 32'd3);
    set_in(ADD, 5'd7, 5'd0, LD, 5'd7, 1'b1, 1'b0);
    tick();
    check("long_c1_viol", 32'(violation), 32'd0);
    tick();
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b0, 1'b0);
    tick();
    check("long_viol", 32'(violation), 32'd1);
    check("long_code", 32'(viol_code), 32'd5);
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b1, 1'b0);
    tick();
    check("unexp2_c1_viol", 32'(violation), 32'd0);
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b0, 1'b0);
    tick();
    check("unexp2_code", 32'(viol_code), 32'd3);
    set_in(ADD, 5'd7, 5'd0, LD, 5'd7, 1'b0, 1'b0);
    tick();
    check("mix_missing_viol", 32'(violation),     32'd1);
    check("mix_missing_code", 32'(viol_code),     32'd1);
    check("mix_first_code",   32'(first_code),    32'd3);
    check("mix_viol_count",   32'(viol_count),    32'd4);
    check("mix_stall_total",  32'(stall_total),   32'd4);
    check("sat_viol_count",   32'(viol_count_s),  32'd3);
    check("sat_stall_total",  32'(stall_total_s), 32'd3);
    check("sat_viol_code",    32'(viol_code_s),   32'd1);
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b0, 1'b0);
    tick();

    // Flush aborts a short run silently; reset discards a run in progress
    do_reset();
    set_in(BEQ, 5'd5, 5'd0, LD, 5'd5, 1'b1, 1'b0);
    tick();
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b0, 1'b1);
    tick();
    check("flush_viol", 32'(violation), 32'd0);
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b1, 1'b0);
    tick();
    check("flush_run2_viol",   32'(violation),   32'd0);
    check("flush_stall_total", 32'(stall_total), 32'd2);
    reset = 1'b0;
    set_in(BUB, 5'd0, 5'd0, BUB, 5'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check("midrst_violation",   32'(violation),   32'd0);
    check("midrst_viol_code",   32'(viol_code),   32'd0);
    check("midrst_first_code",  32'(first_code),  32'd0);
    check("midrst_stall_total", 32'(stall_total), 32'd0);
    check("midrst_viol_count",  32'(viol_count),  32'd0);
    tick();
    check("midrst_idle_viol", 32'(violation), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
